// File: rtl/mod_div_arb.sv
// rtl/mod_div_arb.sv - two-requester round-robin arbiter around one iterative subtract/compare divider (option: MOD_DIVZERO_CHK_EN)
module mod_div_arb #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] divisor0,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_COMP = 3'd2,
        S_SUB  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_id;         // requester owning the running operation
    logic             r_last;       // requester granted most recently
    logic             r_mask_vld;   // masks the just-served requester for one IDLE cycle
    logic             r_mask_id;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_q;
    logic             r_done_id;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_req0_m;
    logic             w_req1_m;
    logic             w_grant;
    logic [WIDTH-1:0] w_dvd;
    logic [WIDTH-1:0] w_dvs;
    logic [WIDTH-1:0] w_rem_sub;
    logic [WIDTH-1:0] w_q_next;
    logic             w_q_sat;
    logic             w_rem_lt;
    logic             w_divzero;

    assign w_req0_m  = req0 & ~(r_mask_vld & ~r_mask_id);
    assign w_req1_m  = req1 & ~(r_mask_vld &  r_mask_id);
    // Both requesting: hand the unit to whoever did not get it last time.
    assign w_grant   = (w_req0_m & w_req1_m) ? ~r_last : w_req1_m;

    assign w_dvd     = r_id ? dividend1 : dividend0;
    assign w_dvs     = r_id ? divisor1  : divisor0;
    assign w_rem_sub = r_rem - r_div;
    // The quotient counter sticks at all-ones rather than wrapping.
    assign w_q_next  = (&r_q) ? r_q : r_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_q_sat   = &w_q_next;
    assign w_rem_lt  = (r_rem < r_div);

`ifdef MOD_DIVZERO_CHK_EN
    assign w_divzero = (w_dvs == '0);
`else
    assign w_divzero = 1'b0;
`endif

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign done_id   = r_done_id;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

    // State register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req0_m | w_req1_m) w_next = S_LOAD;
            S_LOAD: w_next = w_divzero ? S_DONE : S_COMP;
            S_COMP: w_next = w_rem_lt ? S_DONE : S_SUB;
            S_SUB:  w_next = w_q_sat ? S_DONE : S_COMP;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Arbitration bookkeeping and divider datapath; results are captured on entry to DONE
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_id        <= 1'b0;
            r_last      <= 1'b1;
            r_mask_vld  <= 1'b0;
            r_mask_id   <= 1'b0;
            r_rem       <= '0;
            r_div       <= '0;
            r_q         <= '0;
            r_done_id   <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mask_vld <= 1'b0;
                    if (w_req0_m | w_req1_m) begin
                        r_id   <= w_grant;
                        r_last <= w_grant;
                    end
                end
                S_LOAD: begin
                    r_rem <= w_dvd;
                    r_div <= w_dvs;
                    r_q   <= '0;
                    if (w_divzero) begin
                        r_quotient  <= '1;
                        r_remainder <= w_dvd;
                        r_done_id   <= r_id;
                    end
                end
                S_COMP: begin
                    if (w_rem_lt) begin
                        r_quotient  <= r_q;
                        r_remainder <= r_rem;
                        r_done_id   <= r_id;
                    end
                end
                S_SUB: begin
                    r_rem <= w_rem_sub;
                    r_q   <= w_q_next;
                    if (w_q_sat) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_sub;
                        r_done_id   <= r_id;
                    end
                end
                S_DONE: begin
                    r_mask_vld <= 1'b1;
                    r_mask_id  <= r_id;
                end
                default: ;
            endcase
        end
    end

`ifdef MOD_DIVZERO_CHK_EN
    logic r_err;

    // Divide-by-zero flag, set only by the LOAD shortcut and cleared by any normal completion
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (r_state == S_LOAD && w_divzero) begin
            r_err <= 1'b1;
        end else if ((r_state == S_COMP && w_rem_lt) || (r_state == S_SUB && w_q_sat)) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/mod_div_arb.md
MOD_DIV_ARB -- requirements
Module: mod_div_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0, req1  input  1 each  level request from requester 0 / 1.
REQ-005 SHALL have ports dividend0, divisor0, dividend1, divisor1  input  WIDTH each  unsigned operands per requester.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port done_id  output  1  requester served by current/last done.
REQ-009 SHALL have ports quotient, remainder  output  WIDTH each  results, valid from done and held until next done.
REQ-010 SHALL have port err  output  1  divide-by-zero flag, valid with done.

Function
REQ-011 SHALL implement one shared iterative subtract/compare unit; states IDLE, LOAD, COMP, SUB, DONE.
REQ-012 IDLE: any unmasked request -> LOAD, latch granted id; no request -> stay IDLE.
REQ-013 Arbitration SHALL be round-robin: both requesting -> grant the one not granted last; after reset, requester 0 wins first.
REQ-014 LOAD: rem <= dividend[id], div <= divisor[id], q <= 0; -> COMP (divisor-zero exception: REQ-024).
REQ-015 COMP: rem < div -> DONE; otherwise (including rem == div) -> SUB.
REQ-016 SUB: rem <= rem - div (WIDTH bits, no underflow possible), q <= q + 1; -> COMP.
REQ-017 DONE: done = 1 for exactly one cycle; quotient <= q, remainder <= rem, done_id <= id; -> IDLE.
REQ-018 Latency: req first seen in IDLE at cycle 0 -> done at cycle 3 + 2*Q, where Q is the final quotient.
REQ-019 Operands SHALL be sampled only in LOAD; later operand changes do not affect the running operation.
REQ-020 Requester SHALL hold req until its done and drop it the following cycle; the served requester's req SHALL be masked for the single IDLE cycle after DONE.
REQ-021 A request arriving while busy SHALL wait, never abort the running operation.
REQ-022 The q counter SHALL saturate at all-ones; reaching all-ones in SUB forces next state DONE.

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, busy/done/done_id/err = 0, quotient/remainder = 0, last-grant pointer = requester 1 (so requester 0 wins first), independent of CLK, including mid-SUB.

Configuration
REQ-024 With macro MOD_DIVZERO_CHK_EN defined: divisor == 0 in LOAD -> DONE directly; err = 1, quotient = all-ones, remainder = dividend; done at cycle 2.
REQ-025 Without MOD_DIVZERO_CHK_EN: err tied 0; divisor 0 runs COMP/SUB until q saturates (REQ-022), then DONE with quotient = all-ones, remainder = dividend.

Verification
REQ-026 req0, 17/5 -> done at cycle 9, quotient 3, remainder 2, done_id 0, err 0.
REQ-027 req1, 3/7 -> done at cycle 3, quotient 0, remainder 3, done_id 1; 5/5 -> quotient 1, remainder 0, done at cycle 5.
REQ-028 req0 (10/3) and req1 (9/4) asserted same cycle after reset -> first done: id 0, quotient 3, remainder 1; second done: id 1, quotient 2, remainder 1.
REQ-029 req0 and req1 both re-asserted for four operations -> done_id sequence 0,1,0,1; no requester starved.
REQ-030 MOD_DIVZERO_CHK_EN defined, req0 20/0 -> done at cycle 2, err 1, quotient 0xFFFFFFFF, remainder 20.
REQ-031 reset_n pulsed low during SUB of 100/3 -> busy 0 and quotient/remainder 0 before the next CLK edge; a new 8/3 request then completes with quotient 2, remainder 2.
